serial_subtractor: RTL and testbench

- Bit-serial, multi-cycle subtractor; the inverse operation of the team's combinational 4-bit full adder.
- Computes diff = a - b - bin, processing one bit per clock, LSB first, through a registered borrow flip-flop.
- Uses a start/busy/done handshake so a bench can drive it with random operands, the same way it drives the adder.
- Serves as a reference datapath for the sequential-arithmetic labs.

---
 rtl/serial_subtractor.sv | 96 +++++++++
 tb/tb_serial_subtractor.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first.
// start/busy/done handshake; results held until the next completion.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-2:0] r_d_sh;
  logic             r_br;
  logic [CW-1:0]    r_cnt;

  logic             w_d;
  logic             w_br;
  logic [WIDTH-1:0] w_d_nxt;
  logic             w_last;

  assign w_d     = r_a_sh[0] ^ r_b_sh[0] ^ r_br;
  assign w_br    = (~r_a_sh[0] & r_b_sh[0])
                 | (~(r_a_sh[0] ^ r_b_sh[0]) & r_br);
  // Only WIDTH-1 bits are stored; the last bit goes straight to diff.
  assign w_d_nxt = {w_d, r_d_sh};
  assign w_last  = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_d_sh  <= '0;
      r_br    <= 1'b0;
      r_cnt   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      diff    <= '0;
      borrow  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_a_sh  <= a;
            r_b_sh  <= b;
            r_br    <= bin;
            r_cnt   <= '0;
            r_d_sh  <= '0;
            busy    <= 1'b1;
            r_state <= S_RUN;
          end else begin
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_a_sh <= r_a_sh >> 1;
          r_b_sh <= r_b_sh >> 1;
          r_br   <= w_br;
          r_d_sh <= w_d_nxt[WIDTH-1:1];
          r_cnt  <= r_cnt + CW'(1);
          if (w_last) begin
            diff    <= w_d_nxt;
            borrow  <= w_br;
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= S_DONE;
          end
        end
        default: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH=4 and WIDTH=8.
// Stimulus pushes expectations; per-instance monitors pop on done.
module tb_serial_subtractor;

  typedef struct {
    logic [31:0] d;
    logic        br;
    int          cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       start4 = 1'b0;
  logic [3:0] a4 = '0;
  logic [3:0] b4 = '0;
  logic       bin4 = 1'b0;
  logic       busy4, done4, borrow4;
  logic [3:0] diff4;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       bin8 = 1'b0;
  logic       busy8, done8, borrow8;
  logic [7:0] diff8;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  exp_t q4[$];
  exp_t q8[$];
  int lo4 = -1, hi4 = -1, lo8 = -1, hi8 = -1;
  logic [3:0] hold4 = '0;
  logic [7:0] hold8 = '0;
  logic hb4 = 1'b0, hb8 = 1'b0;

  serial_subtractor #(.WIDTH(4)) u_dut4 (
    .clk(clk), .reset(rst), .start(start4),
    .a(a4), .b(b4), .bin(bin4),
    .busy(busy4), .done(done4),
    .diff(diff4), .borrow(borrow4)
  );

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset(rst), .start(start8),
    .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8),
    .diff(diff8), .borrow(borrow8)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name,
                     input longint act, input longint exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s at cyc %0d: got %0d expected %0d",
               name, cyc, act, exp);
    end
  endtask

  // Reference: plain wide arithmetic on the operands.
  function automatic void model(input int w, input logic [31:0] av,
                                input logic [31:0] bv, input logic bi,
                                output logic [31:0] d, output logic br);
    longint t;
    logic [63:0] mask;
    t = longint'(av) - longint'(bv) - longint'(bi);
    mask = (64'd1 << w) - 64'd1;
    d = 32'(t & mask);
    br = (longint'(av) < longint'(bv) + longint'(bi));
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      chk(busy4 == (lo4 >= 0 && cyc >= lo4 && cyc <= hi4),
          "busy4", busy4, !busy4);
      if (done4) begin
        if (q4.size() == 0) begin
          chk(1'b0, "spurious_done4", 1, 0);
        end else begin
          e = q4.pop_front();
          chk(diff4 == e.d[3:0], "diff4", diff4, e.d[3:0]);
          chk(borrow4 == e.br, "borrow4", borrow4, e.br);
          chk(cyc == e.cyc + 4, "latency4", cyc - e.cyc, 4);
          hold4 = e.d[3:0];
          hb4 = e.br;
        end
      end else begin
        chk(diff4 == hold4 && borrow4 == hb4, "hold4",
            {borrow4, diff4}, {hb4, hold4});
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      chk(busy8 == (lo8 >= 0 && cyc >= lo8 && cyc <= hi8),
          "busy8", busy8, !busy8);
      if (done8) begin
        if (q8.size() == 0) begin
          chk(1'b0, "spurious_done8", 1, 0);
        end else begin
          e = q8.pop_front();
          chk(diff8 == e.d[7:0], "diff8", diff8, e.d[7:0]);
          chk(borrow8 == e.br, "borrow8", borrow8, e.br);
          chk(cyc == e.cyc + 8, "latency8", cyc - e.cyc, 8);
          hold8 = e.d[7:0];
          hb8 = e.br;
        end
      end else begin
        chk(diff8 == hold8 && borrow8 == hb8, "hold8",
            {borrow8, diff8}, {hb8, hold8});
      end
    end
  end

  // Called at the post-edge phase; returns #1 after the accepting edge.
  task automatic run_op(input int w, input logic [31:0] av,
                        input logic [31:0] bv, input logic bi,
                        input bit hold, output int acc);
    int n;
    exp_t e;
    n = 0;
    while (((w == 4) ? busy4 : busy8) && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 40) chk(1'b0, "accept_timeout", n, 40);
    if (w == 4) begin
      a4 = av[3:0]; b4 = bv[3:0]; bin4 = bi; start4 = 1'b1;
    end else begin
      a8 = av[7:0]; b8 = bv[7:0]; bin8 = bi; start8 = 1'b1;
    end
    @(posedge clk);
    #1;
    acc = cyc;
    model(w, av, bv, bi, e.d, e.br);
    e.cyc = acc;
    if (w == 4) begin
      q4.push_back(e);
      lo4 = acc; hi4 = acc + 3;
      a4 = 4'($urandom); b4 = 4'($urandom); bin4 = 1'($urandom);
      if (!hold) start4 = 1'b0;
    end else begin
      q8.push_back(e);
      lo8 = acc; hi8 = acc + 7;
      a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
      if (!hold) start8 = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int acc;
    int accs[4];
    int n;
    rst = 1'b1;
    idle(2);
    chk(busy4 == 0 && done4 == 0, "rst_ctl4", {busy4, done4}, 0);
    chk(diff4 == 0 && borrow4 == 0, "rst_out4", {borrow4, diff4}, 0);
    chk(diff8 == 0 && borrow8 == 0, "rst_out8", {borrow8, diff8}, 0);
    rst = 1'b0;
    mon_en = 1'b1;
    idle(1);

    run_op(4, 5, 3, 0, 0, acc);
    idle(6);
    run_op(4, 3, 5, 0, 0, acc);
    run_op(4, 0, 0, 1, 0, acc);
    run_op(4, 15, 15, 0, 0, acc);
    run_op(4, 8, 7, 1, 0, acc);
    idle(6);

    // start pulses mid-run must be ignored
    run_op(4, 9, 2, 0, 0, acc);
    idle(1);
    start4 = 1'b1; a4 = 4'd1; b4 = 4'd1;
    idle(2);
    start4 = 1'b0;
    idle(4);

    // back-to-back with start held high
    for (int i = 0; i < 4; i++)
      run_op(4, $urandom_range(15), $urandom_range(15),
             1'($urandom), (i < 3), accs[i]);
    for (int i = 1; i < 4; i++)
      chk(accs[i] - accs[i-1] == 5, "b2b_gap",
          accs[i] - accs[i-1], 5);
    idle(6);

    // reset aborts a run
    run_op(4, 12, 4, 0, 0, acc);
    idle(1);
    rst = 1'b1;
    @(posedge clk);
    q4.delete(); q8.delete();
    lo4 = -1; hi4 = -1; lo8 = -1; hi8 = -1;
    hold4 = '0; hb4 = 1'b0; hold8 = '0; hb8 = 1'b0;
    #1;
    rst = 1'b0;
    chk(busy4 == 0 && done4 == 0, "abort_ctl", {busy4, done4}, 0);
    chk(diff4 == 0 && borrow4 == 0, "abort_out",
        {borrow4, diff4}, 0);
    idle(8);
    run_op(4, 12, 4, 0, 0, acc);
    idle(6);

    for (int i = 0; i < 10; i++)
      run_op(4, $urandom_range(15), $urandom_range(15),
             1'($urandom), 1'($urandom), acc);
    start4 = 1'b0;
    for (int i = 0; i < 10; i++)
      run_op(8, $urandom_range(255), $urandom_range(255),
             1'($urandom), 1'($urandom), acc);
    run_op(8, 0, 255, 1, 0, acc);
    run_op(8, 255, 0, 0, 0, acc);
    start8 = 1'b0;

    n = 0;
    while ((q4.size() != 0 || q8.size() != 0) && n < 100) begin
      idle(1);
      n++;
    end
    chk(q4.size() == 0 && q8.size() == 0, "drain",
        q4.size() + q8.size(), 0);
    idle(4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
